// File: rtl/baudrate_generator_prog.sv
// baudrate_generator_prog: programmable oversampling baud-rate generator with tick-aligned divisor reload (optional fractional accumulator under BRG_FRAC_EN); ports i_clk/i_reset/i_enable, i_div_int/i_div_frac/i_div_load in, o_brg_tck/o_bit_tck/o_div_ack/o_div_err out
module baudrate_generator_prog #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [DIV_WIDTH-1:0]  i_div_int,
  input  logic [FRAC_WIDTH-1:0] i_div_frac,
  input  logic                  i_div_load,
  output logic                  o_brg_tck,
  output logic                  o_bit_tck,
  output logic                  o_div_ack,
  output logic                  o_div_err
);
  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [63:0] QUOT = (64'(CLOCK_FREQ) << FRAC_WIDTH) / (64'(BAUD_RATE) * 64'(OVERSAMPLE));
  localparam logic [DIV_WIDTH-1:0] RST_INT = DIV_WIDTH'(QUOT >> FRAC_WIDTH);
  logic [DIV_WIDTH:0]   cnt, period;
  logic [DIV_WIDTH-1:0] div_int, pend_int;
  logic [SUB_W-1:0]     sub;
  logic                 pend_vld, wrap, apply, load_ok, load_bad;
  assign wrap     = i_enable && cnt == period - 1'b1;
  assign apply    = pend_vld && (wrap || !i_enable);
  assign load_ok  = i_div_load && i_div_int >= DIV_WIDTH'(2);
  assign load_bad = i_div_load && i_div_int < DIV_WIDTH'(2);
`ifdef BRG_FRAC_EN
  localparam logic [FRAC_WIDTH-1:0] RST_FRAC = FRAC_WIDTH'(QUOT);
  logic [FRAC_WIDTH-1:0] div_frac, pend_frac, acc;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  ext;
  assign acc_sum = {1'b0, acc} + {1'b0, div_frac};
  assign period  = {1'b0, div_int} + (DIV_WIDTH+1)'(ext);
  // ext marks the period following a carry out of the fractional accumulator
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc       <= '0;
      ext       <= 1'b0;
      div_frac  <= RST_FRAC;
      pend_frac <= '0;
    end else begin
      acc       <= apply ? '0 : wrap ? acc_sum[FRAC_WIDTH-1:0] : acc;
      ext       <= apply ? 1'b0 : wrap ? acc_sum[FRAC_WIDTH] : ext;
      div_frac  <= apply ? pend_frac : div_frac;
      pend_frac <= load_ok ? i_div_frac : pend_frac;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^i_div_frac;
  assign period = {1'b0, div_int};
`endif
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt       <= '0;
      sub       <= '0;
      div_int   <= RST_INT;
      pend_int  <= '0;
      pend_vld  <= 1'b0;
      o_brg_tck <= 1'b0;
      o_bit_tck <= 1'b0;
      o_div_ack <= 1'b0;
      o_div_err <= 1'b0;
    end else begin
      o_brg_tck <= wrap;
      o_bit_tck <= wrap && sub == SUB_W'(OVERSAMPLE-1);
      o_div_ack <= apply;
      o_div_err <= load_bad;
      cnt       <= (apply || wrap) ? '0 : i_enable ? cnt + 1'b1 : cnt;
      sub       <= !wrap ? sub : sub == SUB_W'(OVERSAMPLE-1) ? '0 : sub + 1'b1;
      div_int   <= apply ? pend_int : div_int;
      pend_int  <= load_ok ? i_div_int : pend_int;
      // a load on the apply cycle becomes the next pending value
      pend_vld  <= load_ok ? 1'b1 : apply ? 1'b0 : pend_vld;
    end
  end
endmodule

// File: tb/tb_baudrate_generator_prog.sv
// tb_baudrate_generator_prog: directed self-checking bench for baudrate_generator_prog
module tb_baudrate_generator_prog;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, load = 1'b0, rst2 = 1'b1;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic brg, bit_t, ack, err, brg2, bit2, ack2, err2;
  int cyc = 0, cyc2 = 0, n_chk = 0, n_fail = 0;
  int q_tick[$], q_bit[$], q_ack[$], q_err[$], q_f[$];
  always #5 clk = ~clk;
  baudrate_generator_prog dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_div_int(div_int), .i_div_frac(div_frac),
    .i_div_load(load), .o_brg_tck(brg), .o_bit_tck(bit_t), .o_div_ack(ack), .o_div_err(err)
  );
  baudrate_generator_prog #(.CLOCK_FREQ(168), .BAUD_RATE(1), .OVERSAMPLE(16)) dut_f (
    .i_clk(clk), .i_reset(rst2), .i_enable(1'b1), .i_div_int(16'd0), .i_div_frac(4'd0),
    .i_div_load(1'b0), .o_brg_tck(brg2), .o_bit_tck(bit2), .o_div_ack(ack2), .o_div_err(err2)
  );
  always @(posedge clk) begin
    #1;
    if (rst) cyc = 0;
    else begin
      cyc++;
      if (brg) q_tick.push_back(cyc);
      if (bit_t) q_bit.push_back(cyc);
      if (ack) q_ack.push_back(cyc);
      if (err) q_err.push_back(cyc);
    end
    if (rst2) cyc2 = 0;
    else begin
      cyc2++;
      if (brg2 && q_f.size() < 5) q_f.push_back(cyc2);
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int qv(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction
  task automatic wait_cyc(input int n);
    for (int k = 0; k < 20000 && cyc != n; k++) @(negedge clk);
    check("wait_cyc", cyc, n);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    en = 1'b1;
    @(negedge clk);
    check("rst_brg", int'(brg), 0);
    check("rst_bit", int'(bit_t), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    q_tick.delete(); q_bit.delete(); q_ack.delete(); q_err.delete();
  endtask
  task automatic load_at(input int n, input int d);
    wait_cyc(n - 1);
    load = 1'b1;
    div_int = 16'(d);
    @(negedge clk);
    load = 1'b0;
  endtask
  initial begin
    int fexp[5];
`ifdef BRG_FRAC_EN
    fexp = '{10, 20, 31, 41, 52};
`else
    fexp = '{10, 20, 30, 40, 50};
`endif
    do_reset();
    rst2 = 1'b0;
    wait_cyc(1310);
    check("def_tick0", qv(q_tick, 0), 651);
    check("def_tick1", qv(q_tick, 1), 1302);
    check("def_ntick", q_tick.size(), 2);
    for (int i = 0; i < 5; i++) check($sformatf("frac_tick%0d", i), qv(q_f, i), fexp[i]);
    wait_cyc(10420);
    check("def_bit0", qv(q_bit, 0), 10416);
    check("def_nbit", q_bit.size(), 1);
    check("def_ntick16", q_tick.size(), 16);
    check("def_nack", q_ack.size(), 0);
    check("def_nerr", q_err.size(), 0);
    do_reset();
    load_at(100, 10);
    wait_cyc(700);
    check("ld_ack", qv(q_ack, 0), 651);
    check("ld_nack", q_ack.size(), 1);
    check("ld_tick0", qv(q_tick, 0), 651);
    check("ld_tick1", qv(q_tick, 1), 661);
    check("ld_tick2", qv(q_tick, 2), 671);
    check("ld_tick3", qv(q_tick, 3), 681);
    do_reset();
    load_at(100, 1);
    wait_cyc(1310);
    check("bad_err", qv(q_err, 0), 100);
    check("bad_nerr", q_err.size(), 1);
    check("bad_nack", q_ack.size(), 0);
    check("bad_tick1", qv(q_tick, 1), 1302);
    do_reset();
    wait_cyc(300);
    en = 1'b0;
    wait_cyc(350);
    check("en_frozen", q_tick.size(), 0);
    en = 1'b1;
    wait_cyc(750);
    check("en_tick0", qv(q_tick, 0), 701);
    check("en_ntick", q_tick.size(), 1);
    do_reset();
    load_at(100, 20);
    wait_cyc(399);
    do_reset();
    wait_cyc(660);
    check("rst_ld_tick", qv(q_tick, 0), 651);
    check("rst_ld_nack", q_ack.size(), 0);
    do_reset();
    load_at(651, 10);
    wait_cyc(1320);
    check("tk_ld_ack", qv(q_ack, 0), 1302);
    check("tk_ld_tick1", qv(q_tick, 1), 1302);
    check("tk_ld_tick2", qv(q_tick, 2), 1312);
    do_reset();
    wait_cyc(200);
    en = 1'b0;
    load_at(205, 10);
    wait_cyc(210);
    en = 1'b1;
    wait_cyc(230);
    check("dis_ld_ack", qv(q_ack, 0), 206);
    check("dis_tick0", qv(q_tick, 0), 220);
    check("dis_tick1", qv(q_tick, 1), 230);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
